// File: rtl/adder_pkg.sv
// Shared sizing constants for the carry-select adder and its segment blocks.
package adder_pkg;
  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_BLOCK = 4;
endpackage

// File: rtl/csa_block.sv
// One carry-select segment: two speculative adds (carry-in 0 and 1), picked by the incoming block carry.
module csa_block
  import adder_pkg::*;
#(
  parameter int BLOCK = ADDER_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             sel_carry,
  output logic [BLOCK-1:0] sum,
  output logic             carry
);

  logic [BLOCK:0] res0;
  logic [BLOCK:0] res1;

  assign res0 = {1'b0, a} + {1'b0, b};
  assign res1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  // Only the mux sits on the carry chain; both adds settle in parallel.
  assign sum   = sel_carry ? res1[BLOCK-1:0] : res0[BLOCK-1:0];
  assign carry = sel_carry ? res1[BLOCK]     : res0[BLOCK];

endmodule

// File: rtl/carry_select_adder32.sv
// Registered carry-select adder: s = a + b + cin with the carry-out kept in s[WIDTH] and mirrored on cout.
module carry_select_adder32
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int BLOCK = ADDER_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   s,
  output logic             cout
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK;

  logic [NUM_BLOCKS:0] blk_carry;
  logic [WIDTH-1:0]    sum_w;
  logic [WIDTH:0]      s_d;
  logic [WIDTH:0]      s_q;

  assign blk_carry[0] = cin;

  // Segment 0 uses the same block with cin as its select, which reduces to a plain add.
  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_seg
    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a         (a[k*BLOCK +: BLOCK]),
      .b         (b[k*BLOCK +: BLOCK]),
      .sel_carry (blk_carry[k]),
      .sum       (sum_w[k*BLOCK +: BLOCK]),
      .carry     (blk_carry[k+1])
    );
  end

  assign s_d = {blk_carry[NUM_BLOCKS], sum_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s    = s_q;
  assign cout = s_q[WIDTH];

endmodule

// File: tb/tb_carry_select_adder32.sv
// Directed and randomized checks of the registered carry-select adder at several segment widths.
module tb_carry_select_adder32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [32:0] s4, s1, s8, s32;
  logic        c4, c1, c8, c32;

  int tests_run;
  int tests_failed;

  carry_select_adder32 #(.WIDTH(32), .BLOCK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s4), .cout(c4));
  carry_select_adder32 #(.WIDTH(32), .BLOCK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s1), .cout(c1));
  carry_select_adder32 #(.WIDTH(32), .BLOCK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s8), .cout(c8));
  carry_select_adder32 #(.WIDTH(32), .BLOCK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s32), .cout(c32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [32:0] exp);
    check({tag, " s/B4"},  s4,  exp);
    check({tag, " co/B4"}, {32'd0, c4},  {32'd0, exp[32]});
    check({tag, " s/B1"},  s1,  exp);
    check({tag, " co/B1"}, {32'd0, c1},  {32'd0, exp[32]});
    check({tag, " s/B8"},  s8,  exp);
    check({tag, " co/B8"}, {32'd0, c8},  {32'd0, exp[32]});
    check({tag, " s/B32"}, s32, exp);
    check({tag, " co/B32"}, {32'd0, c32}, {32'd0, exp[32]});
  endtask

  // Drive one vector, clock it in, and compare just after the edge.
  task automatic apply(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic [32:0] exp);
    a = va; b = vb; cin = vc;
    @(posedge clk);
    #1;
    check_all(tag, exp);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_all("reset", 33'h0);
    @(posedge clk);
    #1;
    check_all("reset_hold", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("basic",      32'd4,         32'd3,         1'b0, 33'h0_0000_0007);
    apply("cin_ripple", 32'hFFFF_FFFF, 32'h0,         1'b1, 33'h1_0000_0000);
    apply("max_cin1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    apply("max_cin0",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
    apply("zero",       32'h0,         32'h0,         1'b0, 33'h0);
    apply("bnd4",       32'h0000_000F, 32'd1,         1'b0, 33'h0_0000_0010);
    apply("bnd8",       32'h0000_00FF, 32'd1,         1'b0, 33'h0_0000_0100);
    apply("bnd12",      32'h0000_0FFF, 32'd1,         1'b0, 33'h0_0000_1000);
    apply("bnd16",      32'h0000_FFFF, 32'd1,         1'b0, 33'h0_0001_0000);
    apply("bnd20",      32'h000F_FFFF, 32'd1,         1'b0, 33'h0_0010_0000);
    apply("bnd24",      32'h00FF_FFFF, 32'd1,         1'b0, 33'h0_0100_0000);
    apply("bnd28",      32'h0FFF_FFFF, 32'd1,         1'b0, 33'h0_1000_0000);
    apply("bnd_cin",    32'h0FFF_FFFF, 32'd0,         1'b1, 33'h0_1000_0000);
    apply("alt",        32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
    apply("alt_nc",     32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
    apply("mid",        32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
    apply("mixed",      32'h1234_5678, 32'h0FED_CBA9, 1'b1, 33'h0_2222_2222);

    // Mid-operation reset clears the result between edges.
    apply("pre_rst",    32'd5,         32'd6,         1'b0, 33'h0_0000_000B);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst",   32'd1,         32'd1,         1'b1, 33'h0_0000_0003);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ra, rb;
      logic        rc;
      logic [32:0] exp;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      exp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      apply("rand", ra, rb, rc, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
